// File: rtl/xornc_decode_buffer_pkg.sv
// Shared types and constants for the XOR network-coding decode buffer.
// Packet ID layout, port indices and coded-flag encoding shared with the encoder logic.
package xornc_decode_buffer_pkg;

  // Router direction indices.
  localparam int unsigned IDX_IP = 0;
  localparam int unsigned IDX_W  = 1;
  localparam int unsigned IDX_E  = 2;
  localparam int unsigned IDX_S  = 3;
  localparam int unsigned IDX_N  = 4;
  localparam int unsigned IDX_D  = 5;
  localparam int unsigned IDX_U  = 6;

  // Packet ID = {x, y, z, seq}.
  localparam int unsigned ID_X_W   = 3;
  localparam int unsigned ID_Y_W   = 3;
  localparam int unsigned ID_Z_W   = 2;
  localparam int unsigned ID_SEQ_W = 4;
  localparam int unsigned ID_W_DEF = ID_X_W + ID_Y_W + ID_Z_W + ID_SEQ_W;

  localparam logic CODED_FLAG  = 1'b1;
  localparam logic NATIVE_FLAG = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StEmit
  } dec_state_e;

endpackage

// File: rtl/xornc_decode_buffer_if.sv
// Ingress/egress packet channel of the decode buffer.
// The slave modport is the decode buffer; the master is the crossbar/IP side.
interface xornc_decode_buffer_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 12
);
  logic              in_valid;
  logic              in_ready;
  logic              in_coded;
  logic [ID_W-1:0]   in_id_a;
  logic [ID_W-1:0]   in_id_b;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ID_W-1:0]   out_id;
  logic [DATA_W-1:0] out_data;
  logic              out_decoded;

  modport slave (
    input  in_valid, in_coded, in_id_a, in_id_b, in_data, out_ready,
    output in_ready, out_valid, out_id, out_data, out_decoded
  );

  modport master (
    output in_valid, in_coded, in_id_a, in_id_b, in_data, out_ready,
    input  in_ready, out_valid, out_id, out_data, out_decoded
  );
endinterface

// File: rtl/xornc_decode_cam.sv
// Native-packet cache: DEPTH x {valid, id, data}, two lookup ports, one write port.
// A write whose ID is already cached overwrites in place; otherwise it replaces the oldest entry.
module xornc_decode_cam #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 12,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   lk_id_a_i,
  input  logic [ID_W-1:0]   lk_id_b_i,
  output logic              hit_a_o,
  output logic              hit_b_o,
  output logic [DATA_W-1:0] data_a_o,
  output logic [DATA_W-1:0] data_b_o,
  input  logic              wr_en_i,
  input  logic [ID_W-1:0]   wr_id_i,
  input  logic [DATA_W-1:0] wr_data_i
);
  localparam int unsigned IdxW = $clog2(DEPTH);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ID_W-1:0]   id_q   [DEPTH];
  logic [ID_W-1:0]   id_d   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [IdxW-1:0]   wr_ptr_q, wr_ptr_d;

  logic [IdxW-1:0] idx_a, idx_b, idx_w, tgt;
  logic            hit_w;

  always_comb begin
    hit_a_o = 1'b0;
    hit_b_o = 1'b0;
    hit_w   = 1'b0;
    idx_a   = '0;
    idx_b   = '0;
    idx_w   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && id_q[i] == lk_id_a_i) begin
        hit_a_o = 1'b1;
        idx_a   = IdxW'(i);
      end
      if (valid_q[i] && id_q[i] == lk_id_b_i) begin
        hit_b_o = 1'b1;
        idx_b   = IdxW'(i);
      end
      if (valid_q[i] && id_q[i] == wr_id_i) begin
        hit_w = 1'b1;
        idx_w = IdxW'(i);
      end
    end
  end

  assign data_a_o = data_q[idx_a];
  assign data_b_o = data_q[idx_b];

  always_comb begin
    valid_d  = valid_q;
    id_d     = id_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    tgt      = hit_w ? idx_w : wr_ptr_q;
    if (wr_en_i) begin
      valid_d[tgt] = 1'b1;
      id_d[tgt]    = wr_id_i;
      data_d[tgt]  = wr_data_i;
      // DEPTH is a power of two, so the pointer wraps naturally.
      if (!hit_w) wr_ptr_d = wr_ptr_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      id_q     <= id_d;
      data_q   <= data_d;
    end
  end
endmodule

// File: rtl/xornc_decode_buffer.sv
// XOR network-coding decode buffer at the local ejection port: caches natives, decodes coded pairs.
// Define XORNC_DEC_STATS_EN to build the saturating stat_* counters; otherwise they read 0.
module xornc_decode_buffer
  import xornc_decode_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 12,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  xornc_decode_buffer_if.slave    bus,
  output logic                    miss_pulse,
  output logic [CNT_W-1:0]        stat_decoded,
  output logic [CNT_W-1:0]        stat_miss,
  output logic [CNT_W-1:0]        stat_dup
);
  dec_state_e        state_q, state_d;
  logic              coded_q, coded_d;
  logic [ID_W-1:0]   id_a_q, id_a_d, id_b_q, id_b_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              out_valid_q, out_valid_d, out_decoded_q, out_decoded_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              hit_a, hit_b, wr_en, miss, dup, dec_inc;
  logic [DATA_W-1:0] data_a, data_b, wr_data;
  logic [ID_W-1:0]   wr_id;

  xornc_decode_cam #(
    .DATA_W(DATA_W),
    .ID_W  (ID_W),
    .DEPTH (DEPTH)
  ) u_cam (
    .clk      (clk),
    .rst      (rst),
    .lk_id_a_i(id_a_q),
    .lk_id_b_i(id_b_q),
    .hit_a_o  (hit_a),
    .hit_b_o  (hit_b),
    .data_a_o (data_a),
    .data_b_o (data_b),
    .wr_en_i  (wr_en),
    .wr_id_i  (wr_id),
    .wr_data_i(wr_data)
  );

  assign bus.in_ready    = (state_q == StIdle) && !rst;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_id      = out_id_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_decoded = out_decoded_q;
  assign miss_pulse      = miss;

  always_comb begin
    state_d       = state_q;
    coded_d       = coded_q;
    id_a_d        = id_a_q;
    id_b_d        = id_b_q;
    data_d        = data_q;
    out_valid_d   = out_valid_q;
    out_id_d      = out_id_q;
    out_data_d    = out_data_q;
    out_decoded_d = out_decoded_q;
    wr_en         = 1'b0;
    wr_id         = id_a_q;
    wr_data       = data_q;
    miss          = 1'b0;
    dup           = 1'b0;
    dec_inc       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && bus.in_ready) begin
          coded_d = bus.in_coded;
          id_a_d  = bus.in_id_a;
          id_b_d  = bus.in_id_b;
          data_d  = bus.in_data;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (coded_q == NATIVE_FLAG) begin
          wr_en         = 1'b1;
          out_valid_d   = 1'b1;
          out_id_d      = id_a_q;
          out_data_d    = data_q;
          out_decoded_d = 1'b0;
          state_d       = StEmit;
        end else if (hit_a && hit_b) begin
          dup     = 1'b1;
          state_d = StIdle;
        end else if (!hit_a && !hit_b) begin
          miss    = 1'b1;
          state_d = StIdle;
        end else begin
          // Exactly one partner cached: recover the other and cache it as a native.
          wr_en         = 1'b1;
          wr_id         = hit_a ? id_b_q : id_a_q;
          wr_data       = data_q ^ (hit_a ? data_a : data_b);
          out_valid_d   = 1'b1;
          out_id_d      = wr_id;
          out_data_d    = wr_data;
          out_decoded_d = 1'b1;
          state_d       = StEmit;
        end
      end
      StEmit: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          dec_inc     = out_decoded_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      coded_q       <= 1'b0;
      id_a_q        <= '0;
      id_b_q        <= '0;
      data_q        <= '0;
      out_valid_q   <= 1'b0;
      out_id_q      <= '0;
      out_data_q    <= '0;
      out_decoded_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      coded_q       <= coded_d;
      id_a_q        <= id_a_d;
      id_b_q        <= id_b_d;
      data_q        <= data_d;
      out_valid_q   <= out_valid_d;
      out_id_q      <= out_id_d;
      out_data_q    <= out_data_d;
      out_decoded_q <= out_decoded_d;
    end
  end

`ifdef XORNC_DEC_STATS_EN
  logic [CNT_W-1:0] stat_dec_q, stat_dec_d, stat_miss_q, stat_miss_d, stat_dup_q, stat_dup_d;

  // Saturate at all-ones rather than wrapping.
  always_comb begin
    stat_dec_d  = (dec_inc && stat_dec_q != '1) ? stat_dec_q + CNT_W'(1) : stat_dec_q;
    stat_miss_d = (miss && stat_miss_q != '1) ? stat_miss_q + CNT_W'(1) : stat_miss_q;
    stat_dup_d  = (dup && stat_dup_q != '1) ? stat_dup_q + CNT_W'(1) : stat_dup_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_dec_q  <= '0;
      stat_miss_q <= '0;
      stat_dup_q  <= '0;
    end else begin
      stat_dec_q  <= stat_dec_d;
      stat_miss_q <= stat_miss_d;
      stat_dup_q  <= stat_dup_d;
    end
  end

  assign stat_decoded = stat_dec_q;
  assign stat_miss    = stat_miss_q;
  assign stat_dup     = stat_dup_q;
`else
  logic unused_stats;
  assign unused_stats = dup ^ dec_inc;
  assign stat_decoded = '0;
  assign stat_miss    = '0;
  assign stat_dup     = '0;
`endif
endmodule

// File: doc/xornc_decode_buffer.md
Name: xornc_decode_buffer

Overview:
Receiving end of the XOR network-coding scheme. Sits at the router's local (IP) ejection path, downstream of the crossbar. Native packets are passed to the IP and cached. Each coded packet (payload = A xor B, carrying both packet IDs) is decoded against the cached partner, and the recovered native packet is delivered to the IP.

Parameters:
DATA_W, 64, payload width of one packet (single-flit packets)
ID_W, 12, packet ID width: {source XYZ address, sequence number}
DEPTH, 8, native-packet cache entries (power of 2, >=2)
CNT_W, 16, statistics counter width (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  upstream packet valid
in_ready  out  1  block can accept a packet
in_coded  in  1  1 = XOR-coded packet, 0 = native packet
in_id_a  in  ID_W  native ID, or first constituent ID when coded
in_id_b  in  ID_W  second constituent ID (ignored when native)
in_data  in  DATA_W  payload
out_valid  out  1  delivered packet valid
out_ready  in  1  IP accepts packet
out_id  out  ID_W  ID of delivered native packet
out_data  out  DATA_W  delivered payload
out_decoded  out  1  1 = payload was recovered by XOR
miss_pulse  out  1  one-cycle pulse: coded packet dropped because no partner was found
stat_decoded, stat_miss, stat_dup  out  CNT_W each  statistics counters (optional feature)

Behaviour:
- Reset (async, rst=1): FSM=IDLE; all cache valid bits=0; wr_ptr=0; in_ready=0 while rst is high; out_valid=0; out_id=0; out_data=0; out_decoded=0; miss_pulse=0; stat_*=0.
- FSM states:
  - IDLE:
    - in_ready=1.
    - An in_valid & in_ready handshake registers {coded, id_a, id_b, data}; go to LOOKUP.
  - LOOKUP (1 cycle):
    - in_ready=0.
    - Parallel compare of id_a and id_b against all valid cache entries.
    - Native packet:
      - If id_a hits entry k, overwrite entry k; wr_ptr is unchanged.
      - Otherwise write entry wr_ptr, set its valid bit, and advance wr_ptr mod DEPTH (oldest entry evicted).
      - Output: out_id=id_a, out_data=data, out_decoded=0. Go to EMIT.
    - Coded packet, exactly one constituent hits (say id_a hits entry k):
      - out_id=id_b, out_data=data xor cache[k].data, out_decoded=1.
      - The recovered packet is also inserted into the cache using the native insertion rule. Go to EMIT.
      - Symmetric when only id_b hits.
    - Coded packet, both hit: duplicate; drop it; no output; stat_dup+1. Go to IDLE.
    - Coded packet, neither hits: drop it; miss_pulse=1 for this cycle; stat_miss+1. Go to IDLE.
  - EMIT:
    - out_valid=1, held stable until out_ready.
    - On the cycle with out_valid & out_ready: go to IDLE, out_valid=0 next cycle.
    - If out_decoded, stat_decoded+1.
- Latency: handshake in cycle T, out_valid asserted in cycle T+2 (native or decoded). Throughput is one packet per 3 cycles when out_ready is held high.
- Cache writes happen only in LOOKUP. A packet accepted after EMIT therefore always sees the previous insertion.
- in_id_a == in_id_b on a coded packet: treated as a duplicate (both-hit) if the ID is cached, otherwise as a miss.
- Wrap-around: wr_ptr wraps from DEPTH-1 to 0. An evicted ID then produces a miss for late coded partners.
- Reset asserted mid-EMIT: out_valid drops asynchronously; the in-flight packet is lost.
- Counters saturate at all-ones; they never wrap.

Optional Feature:
Macro XORNC_DEC_STATS_EN.
- Defined: stat_decoded, stat_miss and stat_dup are live saturating counters, updated as specified above.
- Undefined: the counter registers are not built, and the three stat_* ports are tied to 0.
- In both cases miss_pulse is always present.

Decomposition:
- Shared header design_params.vh: direction indices IDX_IP/IDX_W/IDX_E/IDX_S/IDX_N/IDX_D/IDX_U, the packet ID field layout (X/Y/Z address plus sequence-number widths), and the coded-flag encoding. These are shared with the encoding-rule logic.
- One sub-module, xornc_decode_cam:
  - DEPTH entries of {valid, id, data}.
  - Two parallel match ports returning hit flag + index.
  - One write port with wr_ptr management.
- FSM and XOR datapath stay in xornc_decode_buffer.

Test Plan:
1. Native id=0x101, data=0xA5A5 with out_ready=1 -> out_valid at T+2, out_id=0x101, out_data=0xA5A5, out_decoded=0.
2. Native 0x101/0x00FF, then coded a=0x101, b=0x202, data=0x0F0F -> out_id=0x202, out_data=0x0FF0, out_decoded=1, stat_decoded=1. A following coded a=0x303, b=0x202, data=0x1234 is then decodable -> out_id=0x303, out_data=0x1DC4, out_decoded=1.
3. Coded a=0x7AA, b=0x7BB with an empty cache -> no out_valid, miss_pulse for 1 cycle, stat_miss=1, in_ready=1 two cycles later.
4. Natives 0x001..0x009 (DEPTH=8), then coded a=0x001, b=0x050 -> miss (0x001 was evicted). Coded a=0x009, b=0x050 -> decodes 0x050.
5. Native 0x011 with out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0 throughout. Assert rst in cycle 3 -> out_valid=0 immediately, cache empty after reset.
6. Natives 0x021 and 0x022, then coded a=0x021, b=0x022 -> dropped, stat_dup=1 (0 when XORNC_DEC_STATS_EN is undefined), no out_valid.
